// File: rtl/frame_update_sequencer.sv
// frame_update_sequencer
//
// Once per frame, detects the start of vertical blanking from the scan counters and
// issues the game-datapath strobes in a fixed order: paddle commit, ball step, then a
// request/acknowledge collision check. Also gates paddle input with a pause toggle and
// keeps frame/hit counters plus sticky error flags.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   row, col          current scan position (13 bits each)
//   pause_btn         asynchronous pause button, toggles pause on each press
//   paddle_newFrame   one-cycle strobe: paddles commit positions
//   paddle_active     paddle button sampling enable, low while paused
//   ball_step         one-cycle strobe: ball advances one step
//   coll_req          level request for a collision check
//   coll_ack/coll_hit collision check done / contact result (valid with ack)
//   busy              high whenever the sequencer is not idle
//   frame_count       frame events seen, wrapping
//   hit_count         acknowledged hits, saturating
//   timeout_err       sticky, collision check never acknowledged
//   overrun_err       sticky, frame event arrived while a sequence was in flight
module frame_update_sequencer #(
    parameter int unsigned COLS    = 640,
    parameter int unsigned ROWS    = 480,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned HIT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [12:0]      row,
    input  logic [12:0]      col,
    input  logic             pause_btn,
    output logic             paddle_newFrame,
    output logic             paddle_active,
    output logic             ball_step,
    output logic             coll_req,
    input  logic             coll_ack,
    input  logic             coll_hit,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [HIT_W-1:0] hit_count,
    output logic             timeout_err,
    output logic             overrun_err
);

    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPaddle,
        StWaitP,
        StBall,
        StWaitB,
        StColl,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [ToW-1:0]   to_q, to_d;
    logic [15:0]      frame_q, frame_d;
    logic [HIT_W-1:0] hit_q, hit_d;
    logic             to_err_q, to_err_d;
    logic             ov_err_q, ov_err_d;
    logic             cond, cond_q, frame_evt;
    logic             sync1_q, sync2_q, sync3_q, pause_rise;
    logic             paused_q, paused_d;

    // Column 0 is always the first visible column whatever COLS is.
    assign cond       = (row == 13'(ROWS)) && (col == '0) && (COLS > 0);
    // Edge detect so a scan position held for several clocks fires only once.
    assign frame_evt  = cond & ~cond_q;
    assign pause_rise = sync2_q & ~sync3_q;
    // Toggle is visible in the same cycle it is detected, so an IDLE decision uses it.
    assign paused_d   = paused_q ^ pause_rise;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        to_d     = to_q;
        hit_d    = hit_q;
        to_err_d = to_err_q;
        ov_err_d = ov_err_q;
        frame_d  = frame_evt ? frame_q + 16'd1 : frame_q;

        // A frame event during a sequence is dropped but flagged.
        if (frame_evt && (state_q != StIdle)) begin
            ov_err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (frame_evt && !paused_d) begin
                    state_d = StPaddle;
                end
            end
            StPaddle: begin
                state_d  = StWaitP;
                settle_d = '0;
            end
            StWaitP: begin
                if (settle_q == 8'(SETTLE - 1)) begin
                    state_d  = StBall;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            StBall: begin
                state_d  = StWaitB;
                settle_d = '0;
            end
            StWaitB: begin
                if (settle_q == 8'(SETTLE - 1)) begin
                    state_d  = StColl;
                    settle_d = '0;
                    to_d     = '0;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            StColl: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (coll_ack) begin
                    state_d = StDone;
                    if (coll_hit && (hit_q != '1)) begin
                        hit_d = hit_q + 1'b1;
                    end
                end else if (to_q == ToW'(TIMEOUT - 1)) begin
                    state_d  = StDone;
                    to_err_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            settle_q        <= '0;
            to_q            <= '0;
            frame_q         <= '0;
            hit_q           <= '0;
            to_err_q        <= 1'b0;
            ov_err_q        <= 1'b0;
            cond_q          <= 1'b0;
            sync1_q         <= 1'b0;
            sync2_q         <= 1'b0;
            sync3_q         <= 1'b0;
            paused_q        <= 1'b0;
            paddle_newFrame <= 1'b0;
            paddle_active   <= 1'b1;
            ball_step       <= 1'b0;
            coll_req        <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state_q         <= state_d;
            settle_q        <= settle_d;
            to_q            <= to_d;
            frame_q         <= frame_d;
            hit_q           <= hit_d;
            to_err_q        <= to_err_d;
            ov_err_q        <= ov_err_d;
            cond_q          <= cond;
            sync1_q         <= pause_btn;
            sync2_q         <= sync1_q;
            sync3_q         <= sync2_q;
            paused_q        <= paused_d;
            // Outputs are registered from the next state so they align with it.
            paddle_newFrame <= (state_d == StPaddle);
            paddle_active   <= ~paused_d;
            ball_step       <= (state_d == StBall);
            coll_req        <= (state_d == StColl);
            busy            <= (state_d != StIdle);
        end
    end

    assign frame_count = frame_q;
    assign hit_count   = hit_q;
    assign timeout_err = to_err_q;
    assign overrun_err = ov_err_q;

endmodule
